alu_ctrl_seq: RTL

- Parametrised, registered successor to the combinational ALU control decoder.
- Takes ALUOp/funct from the multicycle main control and produces the ALU control code.
- Adds a valid/ready issue handshake and tracks multi-cycle ALU operations (imul, divi) with a latency counter, driving busy/done to the main FSM.
- Flags undefined encodings instead of silently holding stale codes.
- Sits between the main control unit and the ALU.

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_code_decode.sv | 57 +++++
 rtl/alu_ctrl_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU, the main control and the ALU control sequencer.
package alu_pkg;

  // alu_op classes driven by the main control
  localparam int OP_RTYPE = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_ADD   = 3;
  localparam int OP_EXT4  = 4;
  localparam int OP_EXT5  = 5;
  localparam int OP_EXT6  = 6;
  localparam int OP_EXT7  = 7;
  localparam int OP_EXT8  = 8;
  localparam int OP_EXT9  = 9;
  localparam int OP_EXT10 = 10;
  localparam int OP_IMUL  = 11;
  localparam int OP_DIVI  = 12;

  // R-type funct field values
  localparam int F_ADD = 0;
  localparam int F_SUB = 1;
  localparam int F_AND = 2;
  localparam int F_OR  = 3;
  localparam int F_SLT = 4;
  localparam int F_LSL = 5;
  localparam int F_LSR = 6;
  localparam int F_NOT = 7;
  localparam int F_SRA = 8;

  // ALU control codes understood by the datapath ALU
  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_NOT   = 2;
  localparam int ALU_LSL   = 3;
  localparam int ALU_LSR   = 4;
  localparam int ALU_AND   = 5;
  localparam int ALU_OR    = 6;
  localparam int ALU_SLT   = 7;
  localparam int ALU_EXT8  = 8;
  localparam int ALU_EXT9  = 9;
  localparam int ALU_EXT10 = 10;
  localparam int ALU_EXT11 = 11;
  localparam int ALU_EXT12 = 12;
  localparam int ALU_EXT13 = 13;
  localparam int ALU_EXT14 = 14;
  localparam int ALU_IMUL  = 15;
  localparam int ALU_DIVI  = 16;
  localparam int ALU_SRA   = 17;

  // Sequencer state: idle (accepting issues) or executing a multi-cycle op
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_code_decode.sv
// Combinational (alu_op, funct) -> ALU control code decoder with legality
// and multi-cycle classification.
module alu_code_decode
  import alu_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int CNT_W   = 5
) (
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CNT_W-1:0]   code,
  output logic               valid,
  output logic               multi
);

  int code_i;

  // Table lookup; anything outside the tables is reported as not valid
  always_comb begin
    code_i = ALU_ADD;
    valid  = 1'b1;
    case (32'(alu_op))
      OP_RTYPE: begin
        case (32'(funct))
          F_ADD:   code_i = ALU_ADD;
          F_SUB:   code_i = ALU_SUB;
          F_AND:   code_i = ALU_AND;
          F_OR:    code_i = ALU_OR;
          F_SLT:   code_i = ALU_SLT;
          F_LSL:   code_i = ALU_LSL;
          F_LSR:   code_i = ALU_LSR;
          F_NOT:   code_i = ALU_NOT;
          F_SRA:   code_i = ALU_SRA;
          default: valid  = 1'b0;
        endcase
      end
      OP_SUB:   code_i = ALU_SUB;
      OP_SLT:   code_i = ALU_SLT;
      OP_ADD:   code_i = ALU_ADD;
      OP_EXT4:  code_i = ALU_EXT8;
      OP_EXT5:  code_i = ALU_EXT9;
      OP_EXT6:  code_i = ALU_EXT10;
      OP_EXT7:  code_i = ALU_EXT11;
      OP_EXT8:  code_i = ALU_EXT12;
      OP_EXT9:  code_i = ALU_EXT13;
      OP_EXT10: code_i = ALU_EXT14;
      OP_IMUL:  code_i = ALU_IMUL;
      OP_DIVI:  code_i = ALU_DIVI;
      default:  valid  = 1'b0;
    endcase
  end

  assign code  = CNT_W'(code_i);
  assign multi = valid && ((code_i == ALU_IMUL) || (code_i == ALU_DIVI));

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control sequencer: decodes issued (alu_op, funct), holds the
// ALU control code, and tracks multi-cycle imul/divi latency for the main FSM.
//
// Handshake: an issue happens at a rising edge where valid_in && ready_out and
// flush is low. ready_out is high exactly while idle. valid_in while not ready
// is dropped, never queued. Each issue yields exactly one done or one illegal
// pulse, unless it is flushed or reset first.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int CNT_W   = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int LAT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               flush,
  output logic [CNT_W-1:0]   alu_cnt,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output alu_state_e         dbg_state
);

  localparam logic [LAT_W-1:0] MUL_LOAD = LAT_W'(MUL_LAT - 1);
  localparam logic [LAT_W-1:0] DIV_LOAD = LAT_W'(DIV_LAT - 1);

  logic [CNT_W-1:0] dec_code;
  logic             dec_valid;
  logic             dec_multi;
  logic [LAT_W-1:0] lat_load;
  logic             issue;
  alu_state_e       state;
  logic [LAT_W-1:0] counter;

  alu_code_decode #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W),
    .CNT_W   (CNT_W)
  ) u_decode (
    .alu_op (alu_op),
    .funct  (funct),
    .code   (dec_code),
    .valid  (dec_valid),
    .multi  (dec_multi)
  );

  assign ready_out = (state == ST_IDLE);
  assign issue     = valid_in && ready_out && !flush;
  assign dbg_state = state;

  // Remaining-cycle load for the issued multi-cycle op; 0 means "finish next cycle"
  always_comb begin
    lat_load = (dec_code == CNT_W'(ALU_IMUL)) ? MUL_LOAD : DIV_LOAD;
  end

  // Sequencer FSM: counter reaches 0 in the cycle done pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      alu_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            if (!dec_valid) begin
              illegal <= 1'b1;
            end else begin
              alu_cnt <= dec_code;
              if (dec_multi && (lat_load != '0)) begin
                state   <= ST_EXEC;
                counter <= lat_load;
                busy    <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
        end
        ST_EXEC: begin
          if (flush) begin
            state   <= ST_IDLE;
            counter <= '0;
            busy    <= 1'b0;
          end else if (counter <= LAT_W'(1)) begin
            state   <= ST_IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          counter <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
